inert_integrator: RTL and testbench

Inertial integrator that produces the `vld`/actual-angle stream feeding the per-axis PD math blocks. It calibrates gyro rate offsets, integrates offset-compensated pitch/roll/yaw rates into 16-bit signed angles, and optionally pulls pitch and roll toward accelerometer-derived angles. Each accepted sample yields one `vld_out` pulse with updated angles. It sits between the inertial sensor interface and flight control.

---
 rtl/inert_integrator.sv | 163 ++++++++++++++++
 tb/tb_inert_integrator.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inert_integrator.sv
// rtl/inert_integrator.sv - gyro offset calibration and 27-bit angle integration; accel fusion enabled by INERT_FUSION_EN
module inert_integrator #(
  parameter int CAL_SHIFT   = 3,
  parameter int FUSION_STEP = 512
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        strt_cal,
  input  logic        vld,
  input  logic [15:0] ptch_rt,
  input  logic [15:0] roll_rt,
  input  logic [15:0] yaw_rt,
  input  logic [15:0] AX,
  input  logic [15:0] AY,
  output logic [15:0] ptch,
  output logic [15:0] roll,
  output logic [15:0] yaw,
  output logic        vld_out,
  output logic        cal_done
);

  localparam int AW = 16 + CAL_SHIFT;
  localparam int CW = CAL_SHIFT + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((1 << CAL_SHIFT) - 1);
  localparam logic [26:0] INT_MAX = 27'h3FF_FFFF;
  localparam logic [26:0] INT_MIN = 27'h400_0000;

  typedef enum logic [1:0] {IDLE, CAL, RUN} state_t;

  // Axis index 0 = pitch, 1 = roll, 2 = yaw
  state_t        state_q, state_d;
  logic [AW-1:0] acc_q [3];
  logic [AW-1:0] acc_d [3];
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   off_q [3];
  logic [15:0]   off_d [3];
  logic [26:0]   int_q [3];
  logic [26:0]   int_d [3];
  logic          vld_out_q, vld_out_d;
  logic          cal_done_q, cal_done_d;

  logic [15:0]   rate    [3];
  logic [AW-1:0] acc_sum [3];
  logic [16:0]   diff    [3];
  logic [15:0]   comp    [3];
  logic [27:0]   fuse    [3];
  logic [27:0]   int_sum [3];
  logic [26:0]   int_sat [3];

  assign rate[0] = ptch_rt;
  assign rate[1] = roll_rt;
  assign rate[2] = yaw_rt;

`ifdef INERT_FUSION_EN
  logic [15:0] accel [3];
  assign accel[0] = AY;
  assign accel[1] = AX;
  assign accel[2] = 16'h0000;
`else
  logic [31:0] unused_fusion;
  assign unused_fusion = 32'(FUSION_STEP) ^ {AX, AY};
`endif

  // Per-axis datapath: calibration sum, compensated rate, fusion nudge, saturating integrate
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      acc_sum[i] = acc_q[i] + AW'($signed(rate[i]));
      diff[i]    = {rate[i][15], rate[i]} - {off_q[i][15], off_q[i]};
      if (diff[i][16] != diff[i][15]) begin
        comp[i] = diff[i][16] ? 16'h8000 : 16'h7FFF;
      end else begin
        comp[i] = diff[i][15:0];
      end
      fuse[i] = 28'h0;
`ifdef INERT_FUSION_EN
      if (i < 2) begin
        if ($signed(accel[i]) > $signed(int_q[i][26:11])) begin
          fuse[i] = 28'(FUSION_STEP);
        end else if ($signed(accel[i]) < $signed(int_q[i][26:11])) begin
          fuse[i] = -28'(FUSION_STEP);
        end
      end
`endif
      int_sum[i] = {int_q[i][26], int_q[i]} + {{12{comp[i][15]}}, comp[i]} + fuse[i];
      if (int_sum[i][27] != int_sum[i][26]) begin
        int_sat[i] = int_sum[i][27] ? INT_MIN : INT_MAX;
      end else begin
        int_sat[i] = int_sum[i][26:0];
      end
    end
  end

  // Mode sequencing and next-state selection; strt_cal overrides any pending sample
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    off_d      = off_q;
    int_d      = int_q;
    vld_out_d  = 1'b0;
    cal_done_d = 1'b0;
    if (strt_cal) begin
      state_d = CAL;
      cnt_d   = '0;
      for (int i = 0; i < 3; i++) acc_d[i] = '0;
    end else begin
      case (state_q)
        CAL: begin
          if (vld) begin
            cnt_d = cnt_q + 1'b1;
            for (int i = 0; i < 3; i++) acc_d[i] = acc_sum[i];
            if (cnt_q == CNT_LAST) begin
              for (int i = 0; i < 3; i++) begin
                off_d[i] = 16'($signed(acc_sum[i]) >>> CAL_SHIFT);
                int_d[i] = '0;
              end
              cal_done_d = 1'b1;
              state_d    = RUN;
            end
          end
        end
        RUN: begin
          if (vld) begin
            int_d     = int_sat;
            vld_out_d = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      vld_out_q  <= 1'b0;
      cal_done_q <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        acc_q[i] <= '0;
        off_q[i] <= '0;
        int_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      vld_out_q  <= vld_out_d;
      cal_done_q <= cal_done_d;
      acc_q      <= acc_d;
      off_q      <= off_d;
      int_q      <= int_d;
    end
  end

  assign ptch     = int_q[0][26:11];
  assign roll     = int_q[1][26:11];
  assign yaw      = int_q[2][26:11];
  assign vld_out  = vld_out_q;
  assign cal_done = cal_done_q;

endmodule

// File: tb/tb_inert_integrator.sv
// tb/tb_inert_integrator.sv - directed self-checking bench for inert_integrator
module tb_inert_integrator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        strt_cal = 1'b0;
  logic        vld = 1'b0;
  logic [15:0] ptch_rt = '0, roll_rt = '0, yaw_rt = '0, AX = '0, AY = '0;
  logic [15:0] ptch, roll, yaw;
  logic        vld_out, cal_done;

  int n_checks = 0;
  int n_fail = 0;

  inert_integrator dut (
    .clk(clk), .rst(rst), .strt_cal(strt_cal), .vld(vld),
    .ptch_rt(ptch_rt), .roll_rt(roll_rt), .yaw_rt(yaw_rt),
    .AX(AX), .AY(AY),
    .ptch(ptch), .roll(roll), .yaw(yaw),
    .vld_out(vld_out), .cal_done(cal_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rates(input logic [15:0] p, input logic [15:0] r, input logic [15:0] y);
    ptch_rt = p;
    roll_rt = r;
    yaw_rt  = y;
  endtask

  task automatic pulse_vld();
    vld = 1'b1;
    tick();
    vld = 1'b0;
  endtask

  task automatic start_cal_8(input logic [15:0] p, input logic [15:0] r, input logic [15:0] y);
    set_rates(p, r, y);
    strt_cal = 1'b1;
    tick();
    strt_cal = 1'b0;
    repeat (8) pulse_vld();
  endtask

  task automatic test_reset();
    tick();
    n_checks++;
    if ({ptch, roll, yaw, vld_out, cal_done} !== 50'h0) begin
      n_fail++;
      $display("FAIL reset_state: got %h %h %h %b %b required all zero", ptch, roll, yaw, vld_out, cal_done);
    end
    rst = 1'b0;
    AX = 16'd0;
    start_cal_8(16'h0000, 16'h0000, 16'h0000);
    n_checks++;
    if (cal_done !== 1'b1) begin n_fail++; $display("FAIL reset_pre_cal_done: got %b required 1", cal_done); end
    ptch_rt = 16'h0800;
    for (int k = 0; k < 3; k++) begin
      AY = 16'(k);
      pulse_vld();
    end
    n_checks++;
    if (ptch !== 16'd3) begin n_fail++; $display("FAIL reset_pre_ptch: got %h required %h", ptch, 16'd3); end
    rst = 1'b1;
    #2;
    n_checks++;
    if (ptch !== 16'd0) begin n_fail++; $display("FAIL reset_async_ptch: got %h required 0000", ptch); end
    tick();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      pulse_vld();
      n_checks++;
      if (vld_out !== 1'b0 || cal_done !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle_pulse%0d: vld_out=%b cal_done=%b required 0 0", k, vld_out, cal_done);
      end
    end
    n_checks++;
    if ({ptch, roll, yaw} !== 48'h0) begin
      n_fail++;
      $display("FAIL reset_idle_angles: got %h %h %h required 0", ptch, roll, yaw);
    end
  endtask

  task automatic test_calibration();
    AX = 16'd0;
    AY = 16'd0;
    start_cal_8(16'h0010, 16'h0000, 16'h0000);
    n_checks++;
    if (cal_done !== 1'b1) begin n_fail++; $display("FAIL cal_done_timing: got %b required 1", cal_done); end
    tick();
    n_checks++;
    if (cal_done !== 1'b0) begin n_fail++; $display("FAIL cal_done_width: got %b required 0", cal_done); end
    for (int k = 0; k < 20; k++) pulse_vld();
    n_checks++;
    if (vld_out !== 1'b1) begin n_fail++; $display("FAIL cal_run_vld_out: got %b required 1", vld_out); end
    n_checks++;
    if (ptch !== 16'd0) begin n_fail++; $display("FAIL cal_offset_ptch: got %h required 0000", ptch); end
  endtask

  task automatic test_integration();
    start_cal_8(16'h0000, 16'h0000, 16'h0000);
    n_checks++;
    if (cal_done !== 1'b1) begin n_fail++; $display("FAIL integ_cal_done: got %b required 1", cal_done); end
    tick();
    set_rates(16'h0800, 16'h0400, 16'hF000);
    for (int k = 0; k < 100; k++) begin
      AY = 16'(k);
      AX = 16'(k / 2);
      pulse_vld();
      n_checks++;
      if (vld_out !== 1'b1) begin n_fail++; $display("FAIL integ_vld_out_hi%0d: got %b required 1", k, vld_out); end
      tick();
      n_checks++;
      if (vld_out !== 1'b0) begin n_fail++; $display("FAIL integ_vld_out_lo%0d: got %b required 0", k, vld_out); end
    end
    n_checks++;
    if (ptch !== 16'd100) begin n_fail++; $display("FAIL integ_ptch: got %h required %h", ptch, 16'd100); end
    n_checks++;
    if (roll !== 16'd50) begin n_fail++; $display("FAIL integ_roll: got %h required %h", roll, 16'd50); end
    n_checks++;
    if (yaw !== 16'hFF38) begin n_fail++; $display("FAIL integ_yaw: got %h required ff38", yaw); end
  endtask

  task automatic test_back_to_back();
    AY = 16'd101;
    AX = 16'd50;
    vld = 1'b1;
    tick();
    n_checks++;
    if (vld_out !== 1'b1) begin n_fail++; $display("FAIL b2b_first: got %b required 1", vld_out); end
    tick();
    vld = 1'b0;
    n_checks++;
    if (vld_out !== 1'b1) begin n_fail++; $display("FAIL b2b_second: got %b required 1", vld_out); end
    tick();
    n_checks++;
    if (vld_out !== 1'b0) begin n_fail++; $display("FAIL b2b_end: got %b required 0", vld_out); end
    n_checks++;
    if ({ptch, roll, yaw} !== {16'd102, 16'd51, 16'hFF34}) begin
      n_fail++;
      $display("FAIL b2b_angles: got %h %h %h required 0066 0033 ff34", ptch, roll, yaw);
    end
  endtask

  task automatic test_saturation();
    AX = 16'd0;
    start_cal_8(16'hFFF0, 16'h0000, 16'h0000);
    n_checks++;
    if (cal_done !== 1'b1) begin n_fail++; $display("FAIL sat_cal_done: got %b required 1", cal_done); end
    set_rates(16'h7FFF, 16'h0000, 16'h0000);
    AY = 16'h7FFF;
    vld = 1'b1;
    repeat (2100) tick();
    n_checks++;
    if (ptch !== 16'h7FFF) begin n_fail++; $display("FAIL sat_pos: got %h required 7fff", ptch); end
    repeat (50) tick();
    n_checks++;
    if (ptch !== 16'h7FFF) begin n_fail++; $display("FAIL sat_pos_hold: got %h required 7fff", ptch); end
    ptch_rt = 16'h8000;
    AY = 16'h8000;
    repeat (4200) tick();
    n_checks++;
    if (ptch !== 16'h8000) begin n_fail++; $display("FAIL sat_neg: got %h required 8000", ptch); end
    repeat (50) tick();
    vld = 1'b0;
    n_checks++;
    if (ptch !== 16'h8000) begin n_fail++; $display("FAIL sat_neg_hold: got %h required 8000", ptch); end
  endtask

  task automatic test_restart();
    AX = 16'd0;
    start_cal_8(16'h0000, 16'h0000, 16'h0000);
    ptch_rt = 16'h0800;
    for (int k = 0; k < 10; k++) begin
      AY = 16'(k);
      pulse_vld();
    end
    n_checks++;
    if (ptch !== 16'd10) begin n_fail++; $display("FAIL restart_pre_ptch: got %h required 000a", ptch); end
    strt_cal = 1'b1;
    vld = 1'b1;
    tick();
    strt_cal = 1'b0;
    vld = 1'b0;
    n_checks++;
    if (vld_out !== 1'b0 || ptch !== 16'd10) begin
      n_fail++;
      $display("FAIL restart_coincident: vld_out=%b ptch=%h required 0 000a", vld_out, ptch);
    end
    ptch_rt = 16'h0000;
    for (int k = 0; k < 7; k++) begin
      pulse_vld();
      n_checks++;
      if (vld_out !== 1'b0 || cal_done !== 1'b0) begin
        n_fail++;
        $display("FAIL restart_cal%0d: vld_out=%b cal_done=%b required 0 0", k, vld_out, cal_done);
      end
    end
    n_checks++;
    if (ptch !== 16'd10) begin n_fail++; $display("FAIL restart_hold: got %h required 000a", ptch); end
    pulse_vld();
    n_checks++;
    if (cal_done !== 1'b1 || ptch !== 16'd0) begin
      n_fail++;
      $display("FAIL restart_done: cal_done=%b ptch=%h required 1 0000", cal_done, ptch);
    end
  endtask

`ifdef INERT_FUSION_EN
  task automatic test_fusion();
    AX = 16'd0;
    start_cal_8(16'h0100, 16'h0000, 16'h0000);
    AY = 16'd100;
    vld = 1'b1;
    repeat (399) tick();
    n_checks++;
    if (ptch !== 16'd99) begin n_fail++; $display("FAIL fuse_up_399: got %h required 0063", ptch); end
    tick();
    n_checks++;
    if (ptch !== 16'd100) begin n_fail++; $display("FAIL fuse_up_400: got %h required 0064", ptch); end
    repeat (20) tick();
    n_checks++;
    if (ptch !== 16'd100) begin n_fail++; $display("FAIL fuse_up_hold: got %h required 0064", ptch); end
    AY = 16'hFFFD;
    repeat (408) tick();
    n_checks++;
    if (ptch !== 16'hFFFE) begin n_fail++; $display("FAIL fuse_dn_408: got %h required fffe", ptch); end
    tick();
    n_checks++;
    if (ptch !== 16'hFFFD) begin n_fail++; $display("FAIL fuse_dn_409: got %h required fffd", ptch); end
    repeat (20) tick();
    vld = 1'b0;
    n_checks++;
    if (ptch !== 16'hFFFD || roll !== 16'd0) begin
      n_fail++;
      $display("FAIL fuse_dn_hold: ptch=%h roll=%h required fffd 0000", ptch, roll);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_calibration();
    test_integration();
    test_back_to_back();
    test_saturation();
    test_restart();
`ifdef INERT_FUSION_EN
    test_fusion();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
